calc_tx_serializer: RTL and testbench

- Parametrised output transmitter for the calculator datapath; generalises the fixed 4-bit DataOut/ClkTx/DOutValid output path.
- Accepts DATA_W-bit result words through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Sends each word as DATA_W/OUT_W chunks on DataOut, timed by a runtime-configurable divided clock ClkTx.
- Sits between the calculator result register and the external receiver.

---
 rtl/calc_tx_serializer.sv | 180 ++++++++++++++++++
 tb/tb_calc_tx_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_tx_serializer.sv
// calc_tx_serializer: buffers DATA_W-bit result words in a small FIFO and
// sends each one as DATA_W/OUT_W chunks on DataOut, timed by a divided
// transmit clock ClkTx. DataOut and DOutValid change only on ClkTx falling
// edges, so the receiver samples on ClkTx rising.
// Optional build macro: TX_PARITY_EN adds DOutPar, the XOR of the chunk on
// DataOut, registered alongside it.
//
// State table
//   state   | meaning
//   ST_IDLE | nothing on the line; waits for a beat with the FIFO non-empty
//   ST_SEND | a word is being shifted out, r_rem chunks still to follow
module calc_tx_serializer #(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 4,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 8,
  parameter int DIV_RST   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  input  logic              ConfigDiv,
  input  logic [DIV_W-1:0]  Din,
  output logic              ClkTx,
  output logic [OUT_W-1:0]  DataOut,
  output logic              DOutValid,
`ifdef TX_PARITY_EN
  output logic              DOutPar,
`endif
  output logic              Busy
);

  localparam int NCH   = DATA_W / OUT_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int REM_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [REM_W-1:0] REM_LAST = REM_W'(NCH - 1);

  generate
    if ((DATA_W % OUT_W) != 0) begin : g_bad_width
      $error("calc_tx_serializer: DATA_W must be a multiple of OUT_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("calc_tx_serializer: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_clk_tx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [REM_W-1:0]  r_rem;
  logic [OUT_W-1:0]  r_data_out;
  logic              r_dout_valid;

  logic              w_beat;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_busy;
  logic              w_cfg;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_shift_next;
  logic [OUT_W-1:0]  w_chunk_load;
  logic [OUT_W-1:0]  w_chunk_shift;

  // Chunk that leaves first for a given word alignment.
  function automatic logic [OUT_W-1:0] lead_chunk(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1 -: OUT_W] : w[OUT_W-1:0];
  endfunction

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = InValid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_beat  = r_clk_tx && (r_cnt == r_div);
  // A word is taken only when the line is free or the last chunk just went.
  assign w_pop   = w_beat && !w_empty && ((r_state == ST_IDLE) || (r_rem == '0));
  assign w_busy  = (r_state != ST_IDLE) || !w_empty;
  assign w_cfg   = ConfigDiv && !w_busy;

  assign w_shift_next  = MSB_FIRST ? (r_shift << OUT_W) : (r_shift >> OUT_W);
  assign w_chunk_load  = lead_chunk(w_head);
  assign w_chunk_shift = lead_chunk(w_shift_next);

  assign InReady   = !w_full;
  assign Busy      = w_busy;
  assign ClkTx     = r_clk_tx;
  assign DataOut   = r_data_out;
  assign DOutValid = r_dout_valid;

  // Divider: count 0..Div, toggle ClkTx at terminal count; reload only when idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div    <= DIV_W'(DIV_RST);
      r_cnt    <= '0;
      r_clk_tx <= 1'b0;
    end else if (w_cfg) begin
      r_div    <= Din;
      r_cnt    <= '0;
      r_clk_tx <= 1'b0;
    end else if (r_cnt == r_div) begin
      r_cnt    <= '0;
      r_clk_tx <= ~r_clk_tx;
    end else begin
      r_cnt    <= r_cnt + DIV_W'(1);
    end
  end

  // FIFO storage; contents are meaningless until the write pointer passes them.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= InData;
  end

  // FIFO pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Serializer FSM: advances only on beats so outputs change on ClkTx fall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_rem        <= '0;
      r_data_out   <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_beat) begin
      if ((r_state == ST_SEND) && (r_rem != '0)) begin
        r_shift    <= w_shift_next;
        r_data_out <= w_chunk_shift;
        r_rem      <= r_rem - REM_W'(1);
      end else if (!w_empty) begin
        r_state      <= ST_SEND;
        r_shift      <= w_head;
        r_data_out   <= w_chunk_load;
        r_dout_valid <= 1'b1;
        r_rem        <= REM_LAST;
      end else begin
        r_state      <= ST_IDLE;
        r_data_out   <= '0;
        r_dout_valid <= 1'b0;
      end
    end
  end

`ifdef TX_PARITY_EN
  logic r_par;

  // Parity follows exactly the chunk chosen by the FSM in the same beat.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_par <= 1'b0;
    end else if (w_beat) begin
      if ((r_state == ST_SEND) && (r_rem != '0)) r_par <= ^w_chunk_shift;
      else if (!w_empty)                         r_par <= ^w_chunk_load;
      else                                       r_par <= 1'b0;
    end
  end

  assign DOutPar = r_par;
`endif

endmodule

// File: tb/tb_calc_tx_serializer.sv
// Directed bench for calc_tx_serializer: one MSB-first and one LSB-first
// instance. Expected chunks are queued when words are pushed; monitors
// collect chunks seen on each ClkTx fall, and the main sequence compares.
module tb_calc_tx_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cfg;
  logic [15:0] in_data;
  logic [7:0]  din;
  logic        in_ready, clk_tx, dout_valid, busy;
  logic [3:0]  data_out;

  logic        rst_l, in_valid_l, cfg_l;
  logic [15:0] in_data_l;
  logic [7:0]  din_l;
  logic        in_ready_l, clk_tx_l, dout_valid_l, busy_l;
  logic [3:0]  data_out_l;

`ifdef TX_PARITY_EN
  logic par, par_l;
`endif

  calc_tx_serializer #(.DATA_W(16), .OUT_W(4), .DEPTH(4), .DIV_W(8),
                       .DIV_RST(3), .MSB_FIRST(1'b1)) dut (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .InData(in_data),
    .InReady(in_ready), .ConfigDiv(cfg), .Din(din), .ClkTx(clk_tx),
    .DataOut(data_out), .DOutValid(dout_valid),
`ifdef TX_PARITY_EN
    .DOutPar(par),
`endif
    .Busy(busy));

  calc_tx_serializer #(.DATA_W(16), .OUT_W(4), .DEPTH(4), .DIV_W(8),
                       .DIV_RST(3), .MSB_FIRST(1'b0)) dut_l (
    .Clk(clk), .Reset(rst_l), .InValid(in_valid_l), .InData(in_data_l),
    .InReady(in_ready_l), .ConfigDiv(cfg_l), .Din(din_l), .ClkTx(clk_tx_l),
    .DataOut(data_out_l), .DOutValid(dout_valid_l),
`ifdef TX_PARITY_EN
    .DOutPar(par_l),
`endif
    .Busy(busy_l));

  int n_checks = 0;
  int n_errors = 0;

  // Monitors: record chunks on ClkTx falls, count valid cycles and valid rises.
  logic [3:0] obs_a[$];
  logic       obs_pa[$];
  int         vcyc_a = 0, vrise_a = 0;
  logic       ptx_a = 1'b0, pv_a = 1'b0;
  logic [3:0] obs_l[$];
  logic       obs_pl[$];
  int         vcyc_l = 0;
  logic       ptx_l = 1'b0;

  always @(negedge clk) begin
    if (ptx_a && !clk_tx && dout_valid) begin
      obs_a.push_back(data_out);
`ifdef TX_PARITY_EN
      obs_pa.push_back(par);
`else
      obs_pa.push_back(1'b0);
`endif
    end
    if (dout_valid) vcyc_a = vcyc_a + 1;
    if (dout_valid && !pv_a) vrise_a = vrise_a + 1;
    ptx_a = clk_tx;
    pv_a  = dout_valid;
  end

  always @(negedge clk) begin
    if (ptx_l && !clk_tx_l && dout_valid_l) begin
      obs_l.push_back(data_out_l);
`ifdef TX_PARITY_EN
      obs_pl.push_back(par_l);
`else
      obs_pl.push_back(1'b0);
`endif
    end
    if (dout_valid_l) vcyc_l = vcyc_l + 1;
    ptx_l = clk_tx_l;
  end

  logic [3:0] exp_a[$];
  logic [3:0] exp_l[$];
  int         exp_total_a = 0, exp_total_l = 0;
  int         rd_a = 0, rd_l = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] w, output bit saw_full);
    int n = 0;
    saw_full = 1'b0;
    while (!in_ready && n < 100) begin
      saw_full = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("push_a_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; in_data = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(w[15-4*i -: 4]);
      exp_total_a++;
    end
  endtask

  // keep = how many leading chunks of this word are expected to reach the line
  task automatic push_l(input logic [15:0] w, input int keep);
    int n = 0;
    while (!in_ready_l && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_l) begin
      check("push_l_ready_timeout", {31'd0, in_ready_l}, 32'd1);
      return;
    end
    in_valid_l = 1'b1; in_data_l = w;
    @(posedge clk); #1;
    in_valid_l = 1'b0;
    for (int i = 0; i < keep; i++) begin
      exp_l.push_back(w[4*i +: 4]);
      exp_total_l++;
    end
  endtask

  task automatic wait_idle_a(input int max);
    int n = 0;
    while ((busy || dout_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_a_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle_l(input int max);
    int n = 0;
    while ((busy_l || dout_valid_l) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_l_timeout", {31'd0, busy_l}, 32'd0);
  endtask

  task automatic compare_a(input string tag);
    logic [3:0] e;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (rd_a < obs_a.size()) begin
        check(tag, {28'd0, obs_a[rd_a]}, {28'd0, e});
`ifdef TX_PARITY_EN
        check("parity_a", {31'd0, obs_pa[rd_a]}, {31'd0, ^e});
`endif
        rd_a++;
      end
    end
    check("chunk_count_a", obs_a.size(), exp_total_a);
    rd_a = obs_a.size();
  endtask

  task automatic compare_l(input string tag);
    logic [3:0] e;
    while (exp_l.size() > 0) begin
      e = exp_l.pop_front();
      if (rd_l < obs_l.size()) begin
        check(tag, {28'd0, obs_l[rd_l]}, {28'd0, e});
`ifdef TX_PARITY_EN
        check("parity_l", {31'd0, obs_pl[rd_l]}, {31'd0, ^e});
`endif
        rd_l++;
      end
    end
    check("chunk_count_l", obs_l.size(), exp_total_l);
    rd_l = obs_l.size();
  endtask

  // ClkTx period of the MSB-first instance in Clk cycles, -1 on timeout.
  task automatic measure_period(output int p);
    logic prev;
    int   n;
    p = -1; prev = clk_tx; n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!prev && clk_tx) break;
      prev = clk_tx; n++;
    end
    if (n < 100) begin
      prev = clk_tx; n = 0;
      while (n < 100) begin
        @(negedge clk);
        n++;
        if (!prev && clk_tx) break;
        prev = clk_tx;
      end
      p = (n < 100) ? n : -1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p, v0, r0, n;
    bit  s, full_seen;

    rst = 1'b1; in_valid = 1'b0; cfg = 1'b0; in_data = '0; din = '0;
    rst_l = 1'b1; in_valid_l = 1'b0; cfg_l = 1'b0; in_data_l = '0; din_l = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_tx", {31'd0, clk_tx}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data_out", {28'd0, data_out}, 32'd0);
    check("rst_l_dout_valid", {31'd0, dout_valid_l}, 32'd0);
    rst = 1'b0; rst_l = 1'b0;
    measure_period(p);
    check("reset_period", p, 8);

    // Single word at Div=1
    cfg = 1'b1; din = 8'd1;
    @(posedge clk); #1;
    cfg = 1'b0;
    measure_period(p);
    check("div1_period", p, 4);
    v0 = vcyc_a;
    push_a(16'hA5C3, s);
    wait_idle_a(200);
    compare_a("single_chunk");
    check("single_valid_cycles", vcyc_a - v0, 16);
    check("single_data_out_after", {28'd0, data_out}, 32'd0);
    check("single_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back, filling the FIFO
    v0 = vcyc_a; r0 = vrise_a; full_seen = 1'b0;
    push_a(16'h1234, s); full_seen |= s;
    push_a(16'h5678, s); full_seen |= s;
    push_a(16'h9ABC, s); full_seen |= s;
    push_a(16'hDEF0, s); full_seen |= s;
    push_a(16'h1111, s); full_seen |= s;
    full_seen |= !in_ready;
    check("fifo_full_seen", {31'd0, full_seen}, 32'd1);
    wait_idle_a(400);
    compare_a("b2b_chunk");
    check("b2b_valid_cycles", vcyc_a - v0, 80);
    check("b2b_valid_rises", vrise_a - r0, 1);

    // Reconfigure while busy is ignored
    push_a(16'h0F0F, s);
    n = 0;
    while (!dout_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_cfg_started", {31'd0, dout_valid}, 32'd1);
    cfg = 1'b1; din = 8'd0;
    @(posedge clk); #1;
    cfg = 1'b0;
    measure_period(p);
    check("busy_cfg_period", p, 4);
    wait_idle_a(200);
    compare_a("busy_cfg_chunk");

    // Reconfigure while idle takes effect
    cfg = 1'b1; din = 8'd0;
    @(posedge clk); #1;
    cfg = 1'b0;
    measure_period(p);
    check("idle_cfg_period", p, 2);
    v0 = vcyc_a;
    push_a(16'hBEEF, s);
    wait_idle_a(200);
    compare_a("div0_chunk");
    check("div0_valid_cycles", vcyc_a - v0, 8);

`ifdef TX_PARITY_EN
    push_a(16'h7100, s);
    wait_idle_a(200);
    compare_a("parity_word_chunk");
`endif

    // LSB-first instance
    push_l(16'hA5C3, 4);
    wait_idle_l(300);
    compare_l("lsb_chunk");

    // Reset mid-word: only the first chunk of 0x1234 may ever appear
    push_l(16'h1234, 1);
    push_l(16'h5678, 0);
    n = 0;
    while (!dout_valid_l && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_started", {31'd0, dout_valid_l}, 32'd1);
    rst_l = 1'b1;
    @(posedge clk); #1;
    check("midrst_dout_valid", {31'd0, dout_valid_l}, 32'd0);
    check("midrst_busy", {31'd0, busy_l}, 32'd0);
    check("midrst_data_out", {28'd0, data_out_l}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_l}, 32'd1);
    rst_l = 1'b0;
    v0 = vcyc_l;
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_valid_after", vcyc_l - v0, 0);
    compare_l("midrst_chunk");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
